// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing the common data bus between execution units
module cdb_arbiter #(
    parameter int N_SRC     = 3,
    parameter int PREG_W    = 7,
    parameter int XLEN      = 32,
    parameter int ROB_TAG_W = 6,
    parameter int SRC_W     = $clog2(N_SRC)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic [N_SRC-1:0]            req_valid_i,
    output logic [N_SRC-1:0]            req_ready_o,
    input  logic [N_SRC-1:0]            req_rd_used_i,
    input  logic [N_SRC*PREG_W-1:0]     req_tag_i,
    input  logic [N_SRC*XLEN-1:0]       req_data_i,
    input  logic [N_SRC*ROB_TAG_W-1:0]  req_rob_tag_i,
    output logic                        cdb_valid_o,
    output logic [PREG_W-1:0]           cdb_tag_o,
    output logic [XLEN-1:0]             cdb_data_o,
    output logic                        cpl_valid_o,
    output logic [ROB_TAG_W-1:0]        cpl_tag_o,
    output logic [SRC_W-1:0]            cpl_src_o
);

    logic [N_SRC-1:0]     hold_valid;
    logic [N_SRC-1:0]     hold_rd_used;
    logic [PREG_W-1:0]    hold_tag     [N_SRC];
    logic [XLEN-1:0]      hold_data    [N_SRC];
    logic [ROB_TAG_W-1:0] hold_rob_tag [N_SRC];

    logic [SRC_W-1:0]     rr_ptr;
    logic [SRC_W-1:0]     rr_next;
    logic [SRC_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic [N_SRC-1:0]     grant;
    logic [N_SRC-1:0]     upper;
    logic [N_SRC-1:0]     fire;

    // Held entries at or above the round-robin pointer take precedence over wrapped ones.
    always_comb begin
        upper = '0;
        for (int i = 0; i < N_SRC; i++) begin
            upper[i] = hold_valid[i] && (SRC_W'(i) >= rr_ptr);
        end
    end

    always_comb begin
        grant_valid = |hold_valid;
        grant_idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (hold_valid[i]) grant_idx = SRC_W'(i);
        end
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (upper[i]) grant_idx = SRC_W'(i);
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < N_SRC; i++) begin
            grant[i] = grant_valid && (grant_idx == SRC_W'(i));
        end
    end

    assign rr_next     = (grant_idx == SRC_W'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
    // A draining entry frees its slot in the same cycle so a streaming unit never bubbles.
    assign req_ready_o = flush_i ? '0 : (~hold_valid | grant);
    assign fire        = req_valid_i & req_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid  <= '0;
            rr_ptr      <= '0;
            cdb_valid_o <= 1'b0;
            cpl_valid_o <= 1'b0;
            cdb_tag_o   <= '0;
            cdb_data_o  <= '0;
            cpl_tag_o   <= '0;
            cpl_src_o   <= '0;
        end else if (flush_i) begin
            hold_valid  <= '0;
            cdb_valid_o <= 1'b0;
            cpl_valid_o <= 1'b0;
        end else begin
            cdb_valid_o <= grant_valid && hold_rd_used[grant_idx];
            cpl_valid_o <= grant_valid;
            if (grant_valid) begin
                rr_ptr     <= rr_next;
                cdb_tag_o  <= hold_tag[grant_idx];
                cdb_data_o <= hold_data[grant_idx];
                cpl_tag_o  <= hold_rob_tag[grant_idx];
                cpl_src_o  <= grant_idx;
            end
            hold_valid <= (hold_valid & ~grant) | fire;
        end
    end

    // Payload carries no reset; hold_valid alone qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (fire[i]) begin
                hold_rd_used[i] <= req_rd_used_i[i];
                hold_tag[i]     <= req_tag_i[i*PREG_W +: PREG_W];
                hold_data[i]    <= req_data_i[i*XLEN +: XLEN];
                hold_rob_tag[i] <= req_rob_tag_i[i*ROB_TAG_W +: ROB_TAG_W];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
    localparam int N  = 3;
    localparam int PW = 7;
    localparam int XL = 32;
    localparam int RW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, flush;
    logic [N-1:0]    req_valid, req_ready, req_rd_used;
    logic [N*PW-1:0] req_tag;
    logic [N*XL-1:0] req_data;
    logic [N*RW-1:0] req_rob;
    logic            cdb_valid, cpl_valid;
    logic [PW-1:0]   cdb_tag;
    logic [XL-1:0]   cdb_data;
    logic [RW-1:0]   cpl_tag;
    logic [1:0]      cpl_src;

    cdb_arbiter #(.N_SRC(N), .PREG_W(PW), .XLEN(XL), .ROB_TAG_W(RW)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rd_used_i(req_rd_used),
        .req_tag_i(req_tag), .req_data_i(req_data), .req_rob_tag_i(req_rob),
        .cdb_valid_o(cdb_valid), .cdb_tag_o(cdb_tag), .cdb_data_o(cdb_data),
        .cpl_valid_o(cpl_valid), .cpl_tag_o(cpl_tag), .cpl_src_o(cpl_src)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Directed table: source i gets payload base+i; expected ready is sampled before the edge.
    typedef struct {
        logic          r;
        logic          f;
        logic [N-1:0]  v;
        logic [N-1:0]  rd;
        logic [PW-1:0] tag;
        logic [XL-1:0] data;
        logic [RW-1:0] rob;
        logic [N-1:0]  e_rdy;
        logic          e_cdb;
        logic          e_cpl;
        logic          e_pay;
        logic [PW-1:0] e_tag;
        logic [XL-1:0] e_data;
        logic [RW-1:0] e_rob;
        logic [1:0]    e_src;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic f, logic [2:0] v, logic [2:0] rd, logic [PW-1:0] tag,
                                logic [XL-1:0] data, logic [RW-1:0] rob, logic [2:0] e_rdy, logic e_cdb,
                                logic e_cpl, logic e_pay, logic [PW-1:0] e_tag, logic [XL-1:0] e_data,
                                logic [RW-1:0] e_rob, logic [1:0] e_src);
        vec_t x;
        x.r = r; x.f = f; x.v = v; x.rd = rd; x.tag = tag; x.data = data; x.rob = rob;
        x.e_rdy = e_rdy; x.e_cdb = e_cdb; x.e_cpl = e_cpl; x.e_pay = e_pay;
        x.e_tag = e_tag; x.e_data = e_data; x.e_rob = e_rob; x.e_src = e_src;
        return x;
    endfunction

    // Reference model: per-source held slot, round-robin pointer, registered outputs.
    logic          m_hv   [N];
    logic          m_rd   [N];
    logic [PW-1:0] m_tag  [N];
    logic [XL-1:0] m_data [N];
    logic [RW-1:0] m_rob  [N];
    int            m_ptr;
    logic          m_cdb_v, m_cpl_v;
    logic [PW-1:0] m_cdb_tag;
    logic [XL-1:0] m_cdb_data;
    logic [RW-1:0] m_cpl_tag;
    logic [1:0]    m_cpl_src;
    logic [N-1:0]  last_rdy;

    task automatic mcycle(input logic r, input logic f, input logic [N-1:0] v, input logic [N-1:0] rd,
                          input logic [N*PW-1:0] tg, input logic [N*XL-1:0] dt, input logic [N*RW-1:0] rb);
        int g;
        logic [N-1:0] rdy;
        rst = r; flush = f; req_valid = v; req_rd_used = rd;
        req_tag = tg; req_data = dt; req_rob = rb;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && m_hv[idx]) g = idx;
        end
        for (int i = 0; i < N; i++) rdy[i] = !f && (!m_hv[i] || g == i);
        #1;
        last_rdy = req_ready;
        if (!r) chk("ready", req_ready, rdy);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
            m_ptr = 0; m_cdb_v = 0; m_cpl_v = 0;
            m_cdb_tag = '0; m_cdb_data = '0; m_cpl_tag = '0; m_cpl_src = '0;
        end else if (f) begin
            for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
            m_cdb_v = 0; m_cpl_v = 0;
        end else begin
            if (g >= 0) begin
                m_cpl_v = 1; m_cdb_v = m_rd[g];
                m_cdb_tag = m_tag[g]; m_cdb_data = m_data[g]; m_cpl_tag = m_rob[g];
                m_cpl_src = 2'(g);
                m_ptr = (g + 1) % N;
                m_hv[g] = 1'b0;
            end else begin
                m_cpl_v = 0; m_cdb_v = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && rdy[i]) begin
                    m_hv[i] = 1'b1; m_rd[i] = rd[i];
                    m_tag[i] = tg[i*PW +: PW]; m_data[i] = dt[i*XL +: XL]; m_rob[i] = rb[i*RW +: RW];
                end
            end
        end
        #1;
        chk("cdb_valid", cdb_valid, m_cdb_v);
        chk("cpl_valid", cpl_valid, m_cpl_v);
        chk("cdb_tag", cdb_tag, m_cdb_tag);
        chk("cdb_data", cdb_data, m_cdb_data);
        chk("cpl_tag", cpl_tag, m_cpl_tag);
        chk("cpl_src", cpl_src, m_cpl_src);
        chk("cdb_implies_cpl", cdb_valid & ~cpl_valid, 0);
        @(negedge clk);
    endtask

    initial begin
        logic [N*PW-1:0] tg;
        logic [N*XL-1:0] dt;
        logic [N*RW-1:0] rb;
        int fire_c, seen_c;

        rst = 1'b1; flush = 1'b0; req_valid = '0; req_rd_used = '0;
        req_tag = '0; req_data = '0; req_rob = '0;

        //      r  f  v       rd      tag  data        rob  e_rdy   cdb cpl pay e_tag e_data      e_rob e_src
        vt.push_back(mk(1, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b000, 0, 0, 1, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b001, 3'b001, 5,  32'hDEAD,   3,  3'b111, 0, 0, 0, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b111, 1, 1, 1, 5,  32'hDEAD,   3,  0));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b111, 0, 0, 0, 0,  32'h0,      0,  0));
        vt.push_back(mk(1, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b000, 0, 0, 1, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b111, 3'b111, 10, 32'h100,    8,  3'b111, 0, 0, 0, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b001, 1, 1, 1, 10, 32'h100,    8,  0));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b011, 1, 1, 1, 11, 32'h101,    9,  1));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b111, 1, 1, 1, 12, 32'h102,    10, 2));
        vt.push_back(mk(0, 0, 3'b101, 3'b101, 20, 32'h200,    16, 3'b111, 0, 0, 0, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b011, 1, 1, 1, 20, 32'h200,    16, 0));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b111, 1, 1, 1, 22, 32'h202,    18, 2));
        vt.push_back(mk(0, 0, 3'b100, 3'b000, 30, 32'h300,    5,  3'b111, 0, 0, 0, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b111, 0, 1, 1, 32, 32'h302,    7,  2));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b111, 0, 0, 0, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b111, 3'b111, 40, 32'h400,    24, 3'b111, 0, 0, 0, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 1, 3'b111, 3'b111, 44, 32'h440,    28, 3'b000, 0, 0, 0, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b111, 0, 0, 0, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b111, 0, 0, 0, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b111, 3'b111, 50, 32'h500,    32, 3'b111, 0, 0, 0, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b001, 1, 1, 1, 50, 32'h500,    32, 0));
        vt.push_back(mk(1, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b000, 0, 0, 1, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b111, 0, 0, 0, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b011, 3'b011, 60, 32'h600,    40, 3'b111, 0, 0, 0, 0,  32'h0,      0,  0));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b101, 1, 1, 1, 60, 32'h600,    40, 0));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b111, 1, 1, 1, 61, 32'h601,    41, 1));
        vt.push_back(mk(0, 0, 3'b000, 3'b000, 0,  32'h0,      0,  3'b111, 0, 0, 0, 0,  32'h0,      0,  0));

        @(negedge clk);
        for (int n = 0; n < vt.size(); n++) begin
            rst = vt[n].r; flush = vt[n].f; req_valid = vt[n].v; req_rd_used = vt[n].rd;
            for (int i = 0; i < N; i++) begin
                req_tag[i*PW +: PW]  = vt[n].tag + PW'(i);
                req_data[i*XL +: XL] = vt[n].data + XL'(i);
                req_rob[i*RW +: RW]  = vt[n].rob + RW'(i);
            end
            #1;
            if (!vt[n].r) chk($sformatf("vec%0d_ready", n), req_ready, vt[n].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_cdb_valid", n), cdb_valid, vt[n].e_cdb);
            chk($sformatf("vec%0d_cpl_valid", n), cpl_valid, vt[n].e_cpl);
            if (vt[n].e_pay) begin
                chk($sformatf("vec%0d_cdb_tag", n), cdb_tag, vt[n].e_tag);
                chk($sformatf("vec%0d_cdb_data", n), cdb_data, vt[n].e_data);
                chk($sformatf("vec%0d_cpl_tag", n), cpl_tag, vt[n].e_rob);
                chk($sformatf("vec%0d_cpl_src", n), cpl_src, vt[n].e_src);
            end
            @(negedge clk);
        end

        // Model-tracked phase starts from reset.
        mcycle(1, 0, '0, '0, '0, '0, '0);

        // LSU streams 8 results with no contention.
        for (int c = 0; c < 10; c++) begin
            tg = '0; dt = '0; rb = '0;
            tg[PW +: PW] = PW'(c + 1); dt[XL +: XL] = XL'(32'h1000 + c); rb[RW +: RW] = RW'(c);
            mcycle(0, 0, (c < 8) ? 3'b010 : 3'b000, 3'b010, tg, dt, rb);
            chk($sformatf("stream%0d_lsu_ready", c), last_rdy[1], 1'b1);
            chk($sformatf("stream%0d_cpl_valid", c), cpl_valid, (c >= 1 && c <= 8));
            if (c >= 1 && c <= 8) chk($sformatf("stream%0d_rob", c), cpl_tag, RW'(c - 1));
        end

        // ALU and BRU stream continuously while one LSU result is injected.
        fire_c = -1; seen_c = -1;
        for (int c = 0; c < 14; c++) begin
            tg = PW'($urandom) | ({(N*PW){1'b0}} | N*PW'($urandom)) << 0;
            dt = {$urandom, $urandom, $urandom};
            rb = '0;
            rb[0 +: RW] = RW'(c % 32); rb[2*RW +: RW] = RW'(c % 32);
            rb[RW +: RW] = 6'd63;
            mcycle(0, 0, (c == 2) ? 3'b111 : 3'b101, 3'b111, tg, dt, rb);
            if (c == 2 && last_rdy[1]) fire_c = c;
            if (fire_c >= 0 && seen_c < 0 && cpl_valid && cpl_src == 2'd1) seen_c = c;
        end
        chk("starvation_bound", (fire_c >= 0 && seen_c > fire_c && seen_c - fire_c <= 3), 1'b1);

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 600; c++) begin
            logic r, f;
            r  = ($urandom_range(0, 49) == 0);
            f  = ($urandom_range(0, 19) == 0);
            tg = {$urandom, $urandom};
            dt = {$urandom, $urandom, $urandom};
            rb = N*RW'($urandom);
            mcycle(r, f, N'($urandom), N'($urandom), tg, dt, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
